mem_stage_unit: RTL and testbench
=================================

Name: mem_stage_unit

Overview:
- Memory-access stage placed directly downstream of the EX/MEM pipeline register.
- Performs word, halfword and byte loads and stores against an internal data RAM.
- Detects misaligned accesses.
- Registers the load result together with the write-back control bundle, so it doubles as the MEM/WB boundary feeding write-back.

Parameters:
ADDR_WIDTH, 10, number of word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words.

Ports:
Clock  in  1  clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold all output registers and block RAM writes this cycle
MemRead_In  in  1  load request
MemWrite_In  in  1  store request
ByteSel_In  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word
L16B_In  in  2  load extension: 00 sign-extend, 01 zero-extend, 1x zero-extend
ALUResult_In  in  32  byte address for memory ops; passthrough result otherwise
WriteData_In  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
MemToReg_In  in  2  write-back source select, passed through
RegDest_In  in  5  destination register, passed through
RegWrite_In  in  1  register write enable, passed through
PC_In  in  32  instruction PC, passed through
ReadData_Out  out  32  extended load data
ALUResult_Out  out  32  registered ALUResult_In
MemToReg_Out  out  2  registered MemToReg_In
RegDest_Out  out  5  registered RegDest_In
RegWrite_Out  out  1  registered RegWrite_In, forced 0 on alignment error
PC_Out  out  32  registered PC_In
AlignErr_Out  out  1  one-cycle flag: misaligned access in previous cycle

Behaviour:
- Reset: on a posedge with Reset=1, clear every output register to 0.
  - RAM contents are not cleared.
  - RAM powers up all-zero via an initial block.
  - No write occurs on a Reset cycle.
  - Reset overrides Stall.
- Addressing:
  - Word index = ALUResult_In[ADDR_WIDTH+1:2]; higher bits are ignored (aliasing).
  - Byte lane = ALUResult_In[1:0]. Little-endian: lane 0 = bits [7:0].
- Alignment:
  - Misaligned when halfword with addr[0]=1, or word/11 with addr[1:0]!=0.
  - Only evaluated when MemRead_In or MemWrite_In is 1.
- Store (MemWrite_In=1, aligned, Stall=0, Reset=0): at the posedge, write the byte-enabled lanes only.
  - Byte: WriteData_In[7:0] to lane addr[1:0].
  - Half: WriteData_In[15:0] to lanes addr[1]*2 and addr[1]*2+1.
  - Word: all four lanes.
  - Untouched lanes keep their contents.
- Load (MemRead_In=1, aligned, MemWrite_In=0): at the posedge, read the addressed word, select the lane(s), extend per L16B_In, and register into ReadData_Out.
  - Latency: 1 cycle, aligned with the passthrough fields.
  - Word loads ignore L16B_In.
- A store at edge N followed by a load of the same address at edge N+1 returns the new data; there is no read/write hazard.
- MemRead_In and MemWrite_In both 1: the store is performed and ReadData_Out = 0.
- ReadData_Out = 0 on any cycle without a successful load.
- Misaligned access:
  - No RAM write; ReadData_Out = 0.
  - AlignErr_Out = 1 and RegWrite_Out = 0 for that result cycle.
  - All other passthroughs are registered normally.
- Stall=1 (and Reset=0):
  - All outputs hold their previous values, including AlignErr_Out.
  - The RAM is not written.
  - Upstream must hold its inputs stable.
- AlignErr_Out is 0 on any unstalled cycle without an error.

Optional Feature:
MEM_ACCESS_COUNT_EN
- Defined: adds two outputs, LoadCount_Out[31:0] and StoreCount_Out[31:0].
  - Each increments on every completed aligned, unstalled load or store.
  - A simultaneous read+write counts as a store only.
  - Both wrap at 2**32 and reset to 0 with Reset.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
1. Reset held 2 cycles, then released: all outputs 0; after RAM init, a word load of addr 0x0 -> ReadData_Out=0x00000000.
2. Word store 0xDEADBEEF @0x10, then at the next edge a word load @0x10 -> ReadData_Out=0xDEADBEEF one cycle later, with RegDest_Out/PC_Out matching the load's inputs.
3. Byte store 0x80 @0x13, then byte load @0x13: L16B=00 -> 0xFFFFFF80; L16B=01 -> 0x00000080. A subsequent word load @0x10 -> 0x80ADBEEF.
4. Halfword load @0x11 (misaligned) with RegWrite_In=1 -> AlignErr_Out=1, RegWrite_Out=0, ReadData_Out=0. Halfword store @0x11 -> RAM unchanged.
5. Stall=1 during a word store 0x12345678 @0x20 -> word at 0x20 unchanged and outputs frozen. Release Stall with the same inputs -> store completes.
6. Reset asserted the same cycle as a store of 0xCAFEF00D @0x30 -> no write (a later load reads the old value); outputs 0. With MEM_ACCESS_COUNT_EN, counters read 0 after reset and 1/1 after one load and one store.

Source files
------------

// File: rtl/mem_stage_unit.sv
// Memory-access stage with internal data RAM; registers the load result and write-back bundle (MEM/WB boundary).
// Optional access counters are enabled by defining MEM_ACCESS_COUNT_EN.
module mem_stage_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  MemRead_In,
    input  logic                  MemWrite_In,
    input  logic [1:0]            ByteSel_In,
    input  logic [1:0]            L16B_In,
    input  logic [31:0]           ALUResult_In,
    input  logic [31:0]           WriteData_In,
    input  logic [1:0]            MemToReg_In,
    input  logic [4:0]            RegDest_In,
    input  logic                  RegWrite_In,
    input  logic [31:0]           PC_In,
    output logic [31:0]           ReadData_Out,
    output logic [31:0]           ALUResult_Out,
    output logic [1:0]            MemToReg_Out,
    output logic [4:0]            RegDest_Out,
    output logic                  RegWrite_Out,
    output logic [31:0]           PC_Out,
    output logic                  AlignErr_Out
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]           LoadCount_Out,
    output logic [31:0]           StoreCount_Out
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           ram [DEPTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  is_half;
    logic                  is_byte;
    logic                  is_word;
    logic                  misaligned;
    logic                  do_write;
    logic                  do_load;
    logic [3:0]            byte_en;
    logic [31:0]           store_data;
    logic [31:0]           rd_word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  zero_ext;
    logic [31:0]           load_data;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
        end
    end

    // Upper address bits are ignored, so the RAM aliases across the address space.
    always_comb begin
        word_idx   = ALUResult_In[ADDR_WIDTH+1:2];
        lane       = ALUResult_In[1:0];
        is_half    = (ByteSel_In == 2'b01);
        is_byte    = (ByteSel_In == 2'b10);
        is_word    = !is_half && !is_byte;
        misaligned = (MemRead_In || MemWrite_In) &&
                     ((is_half && lane[0]) || (is_word && (lane != 2'b00)));
        do_write   = MemWrite_In && !misaligned && !Stall && !Reset;
        do_load    = MemRead_In && !MemWrite_In && !misaligned;
    end

    always_comb begin
        byte_en    = 4'b1111;
        store_data = WriteData_In;
        if (is_byte) begin
            byte_en    = 4'b0001 << lane;
            store_data = {4{WriteData_In[7:0]}};
        end else if (is_half) begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{WriteData_In[15:0]}};
        end
    end

    always_comb begin
        rd_word   = ram[word_idx];
        sel_byte  = rd_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        zero_ext  = (L16B_In != 2'b00);
        load_data = rd_word;
        if (is_byte) begin
            load_data = {{24{!zero_ext && sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_data = {{16{!zero_ext && sel_half[15]}}, sel_half};
        end
    end

    // Plain always here because the RAM is also zeroed by the initial block above.
    always @(posedge Clock) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[word_idx][i*8 +: 8] <= store_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ReadData_Out  <= '0;
            ALUResult_Out <= '0;
            MemToReg_Out  <= '0;
            RegDest_Out   <= '0;
            RegWrite_Out  <= 1'b0;
            PC_Out        <= '0;
            AlignErr_Out  <= 1'b0;
        end else if (!Stall) begin
            ReadData_Out  <= do_load ? load_data : 32'h0;
            ALUResult_Out <= ALUResult_In;
            MemToReg_Out  <= MemToReg_In;
            RegDest_Out   <= RegDest_In;
            RegWrite_Out  <= RegWrite_In && !misaligned;
            PC_Out        <= PC_In;
            AlignErr_Out  <= misaligned;
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    // A combined read+write never qualifies as do_load, so it counts as a store only.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            LoadCount_Out  <= '0;
            StoreCount_Out <= '0;
        end else begin
            if (!Stall && do_load) begin
                LoadCount_Out <= LoadCount_Out + 32'd1;
            end
            if (do_write) begin
                StoreCount_Out <= StoreCount_Out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed self-checking bench for mem_stage_unit: loads, stores, alignment, stall and reset.
module tb_mem_stage_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  byte_sel;
    logic [1:0]  l16b;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [1:0]  mem_to_reg;
    logic [4:0]  reg_dest;
    logic        reg_write;
    logic [31:0] pc;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [1:0]  mem_to_reg_out;
    logic [4:0]  reg_dest_out;
    logic        reg_write_out;
    logic [31:0] pc_out;
    logic        align_err_out;
`ifdef MEM_ACCESS_COUNT_EN
    logic [31:0] load_count_out;
    logic [31:0] store_count_out;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage_unit #(.ADDR_WIDTH(10)) dut (
        .Clock        (clock),
        .Reset        (reset),
        .Stall        (stall),
        .MemRead_In   (mem_read),
        .MemWrite_In  (mem_write),
        .ByteSel_In   (byte_sel),
        .L16B_In      (l16b),
        .ALUResult_In (alu_result),
        .WriteData_In (write_data),
        .MemToReg_In  (mem_to_reg),
        .RegDest_In   (reg_dest),
        .RegWrite_In  (reg_write),
        .PC_In        (pc),
        .ReadData_Out (read_data_out),
        .ALUResult_Out(alu_result_out),
        .MemToReg_Out (mem_to_reg_out),
        .RegDest_Out  (reg_dest_out),
        .RegWrite_Out (reg_write_out),
        .PC_Out       (pc_out),
        .AlignErr_Out (align_err_out)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .LoadCount_Out (load_count_out),
        .StoreCount_Out(store_count_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one access, clocks it in, and leaves time 1 unit past the edge for sampling.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] bsel,
                                 input logic [1:0] ext, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        mem_read   = rd;
        mem_write  = wr;
        byte_sel   = bsel;
        l16b       = ext;
        alu_result = addr;
        write_data = wdata;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        byte_sel   = 2'b00;
        l16b       = 2'b00;
        alu_result = 32'h0;
        write_data = 32'h0;
        mem_to_reg = 2'b00;
        reg_dest   = 5'd0;
        reg_write  = 1'b0;
        pc         = 32'h0;

        // Reset held for two cycles
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_read_data", read_data_out, 32'h0);
        checkOutput("rst_alu_result", alu_result_out, 32'h0);
        checkOutput("rst_mem_to_reg", {30'h0, mem_to_reg_out}, 32'h0);
        checkOutput("rst_reg_dest", {27'h0, reg_dest_out}, 32'h0);
        checkOutput("rst_reg_write", {31'h0, reg_write_out}, 32'h0);
        checkOutput("rst_pc", pc_out, 32'h0);
        checkOutput("rst_align_err", {31'h0, align_err_out}, 32'h0);
`ifdef MEM_ACCESS_COUNT_EN
        checkOutput("rst_load_count", load_count_out, 32'h0);
        checkOutput("rst_store_count", store_count_out, 32'h0);
`endif
        reset = 1'b0;
        reg_dest = 5'd1;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        checkOutput("init_load_0", read_data_out, 32'h0);
        checkOutput("init_reg_dest", {27'h0, reg_dest_out}, 32'd1);

        // Word store then load
        reg_dest = 5'd3; pc = 32'h100;
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 32'h10, 32'hDEADBEEF);
        checkOutput("store_read_zero", read_data_out, 32'h0);
        reg_dest = 5'd7; pc = 32'h104; reg_write = 1'b1; mem_to_reg = 2'b01;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b11, 32'h10, 32'h0);
        checkOutput("word_load", read_data_out, 32'hDEADBEEF);
        checkOutput("word_reg_dest", {27'h0, reg_dest_out}, 32'd7);
        checkOutput("word_pc", pc_out, 32'h104);
        checkOutput("word_reg_write", {31'h0, reg_write_out}, 32'd1);
        checkOutput("word_mem_to_reg", {30'h0, mem_to_reg_out}, 32'd1);
        checkOutput("word_alu_result", alu_result_out, 32'h10);

        // Byte and halfword lanes with extension
        applyStimulus(1'b0, 1'b1, 2'b10, 2'b00, 32'h13, 32'h12345680);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 32'h13, 32'h0);
        checkOutput("byte_sext", read_data_out, 32'hFFFFFF80);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b01, 32'h13, 32'h0);
        checkOutput("byte_zext", read_data_out, 32'h00000080);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b10, 32'h13, 32'h0);
        checkOutput("byte_zext_1x", read_data_out, 32'h00000080);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h0);
        checkOutput("word_after_byte", read_data_out, 32'h80ADBEEF);
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 32'h12, 32'h0);
        checkOutput("half_hi_sext", read_data_out, 32'hFFFF80AD);
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b01, 32'h10, 32'h0);
        checkOutput("half_lo_zext", read_data_out, 32'h0000BEEF);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 32'h10, 32'h0);
        checkOutput("byte_lane0_sext", read_data_out, 32'hFFFFFFEF);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 32'h11, 32'h0);
        checkOutput("byte_lane1_sext", read_data_out, 32'hFFFFFFBE);
        checkOutput("byte_odd_no_err", {31'h0, align_err_out}, 32'd0);

        // Misaligned accesses
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 32'h11, 32'h0);
        checkOutput("mis_half_err", {31'h0, align_err_out}, 32'd1);
        checkOutput("mis_half_regwr", {31'h0, reg_write_out}, 32'd0);
        checkOutput("mis_half_read", read_data_out, 32'h0);
        checkOutput("mis_half_alu", alu_result_out, 32'h11);
        applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 32'h11, 32'h00001111);
        checkOutput("mis_store_err", {31'h0, align_err_out}, 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h0);
        checkOutput("mis_store_nowrite", read_data_out, 32'h80ADBEEF);
        checkOutput("err_clears", {31'h0, align_err_out}, 32'd0);
        checkOutput("regwr_restored", {31'h0, reg_write_out}, 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 32'h12, 32'h0);
        checkOutput("mis_word11_err", {31'h0, align_err_out}, 32'd1);

        // Stall freezes outputs and blocks the write
        pc = 32'h1F0;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h0);
        stall = 1'b1; pc = 32'h200; reg_dest = 5'd9;
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 32'h20, 32'h12345678);
        checkOutput("stall_read_hold", read_data_out, 32'h80ADBEEF);
        checkOutput("stall_pc_hold", pc_out, 32'h1F0);
        checkOutput("stall_alu_hold", alu_result_out, 32'h10);
        checkOutput("stall_dest_hold", {27'h0, reg_dest_out}, 32'd7);
        stall = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h20, 32'h0);
        checkOutput("stall_no_write", read_data_out, 32'h0);
        checkOutput("unstall_pc", pc_out, 32'h200);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 32'h20, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h20, 32'h0);
        checkOutput("unstall_store", read_data_out, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 32'h22, 32'hFFFFABCD);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h20, 32'h0);
        checkOutput("half_store_hi", read_data_out, 32'hABCD5678);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h21, 32'h0);
        stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h20, 32'h0);
        checkOutput("stall_err_hold", {31'h0, align_err_out}, 32'd1);
        stall = 1'b0;

        // Combined read+write stores and returns zero
        applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 32'h24, 32'hAAAA5555);
        checkOutput("rw_read_zero", read_data_out, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h24, 32'h0);
        checkOutput("rw_stored", read_data_out, 32'hAAAA5555);

        // Reset beats a coincident store
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 32'h30, 32'hCAFEF00D);
        checkOutput("rst2_read", read_data_out, 32'h0);
        checkOutput("rst2_pc", pc_out, 32'h0);
        checkOutput("rst2_alu", alu_result_out, 32'h0);
        checkOutput("rst2_regwr", {31'h0, reg_write_out}, 32'd0);
`ifdef MEM_ACCESS_COUNT_EN
        checkOutput("rst2_load_count", load_count_out, 32'h0);
        checkOutput("rst2_store_count", store_count_out, 32'h0);
`endif
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h30, 32'h0);
        checkOutput("rst2_no_write", read_data_out, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 32'h30, 32'h01020304);
`ifdef MEM_ACCESS_COUNT_EN
        checkOutput("cnt_load_1", load_count_out, 32'd1);
        checkOutput("cnt_store_1", store_count_out, 32'd1);
`endif
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 32'h30, 32'h0);
        checkOutput("post_rst_store", read_data_out, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
